// File: rtl/sha256_pad_ctrl.sv
`timescale 1ns/1ps
// sha256_pad_ctrl: packs a message byte stream into 512-bit SHA-256 blocks,
// appends 0x80 / zero fill / 64-bit big-endian bit length, and hands each
// block to the compression core over a valid/ready handshake.
module sha256_pad_ctrl #(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         byte_valid_i,
  input  logic [7:0]   byte_i,
  input  logic         byte_last_i,
  output logic         byte_ready_o,
  output logic [511:0] blk_o,
  output logic         blk_valid_o,
  output logic         blk_first_o,
  output logic         blk_final_o,
  input  logic         core_ready_i,
  output logic         done_o,
  output logic         busy_o
);

  typedef enum logic [2:0] {
    COLLECT,
    PAD,
    SEND,
    LENBLK,
    DONE
  } state_t;

  state_t            state;
  logic [5:0]        idx;
  logic [LEN_W-1:0]  bitlen;
  logic [LEN_W-1:0]  bitlen_inc;
  logic [63:0]       len64;
  logic              first_flag;
  logic              pend_pad0;
  logic              pend_len;
  logic [511:0]      blk_q;

  assign blk_o = blk_q;

  // Zero-extend the running bit count into the 64-bit length field and
  // precompute its value after one more accepted byte.
  always_comb begin
    len64             = '0;
    len64[LEN_W-1:0]  = bitlen;
    bitlen_inc        = bitlen + LEN_W'(8);
  end

  // Block assembly FSM; all handshake/status outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= COLLECT;
      idx          <= '0;
      bitlen       <= '0;
      first_flag   <= 1'b1;
      pend_pad0    <= 1'b0;
      pend_len     <= 1'b0;
      blk_q        <= '0;
      byte_ready_o <= 1'b1;
      blk_valid_o  <= 1'b0;
      blk_first_o  <= 1'b0;
      blk_final_o  <= 1'b0;
      done_o       <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (byte_valid_i) begin
            // Byte k occupies bits [511-8k -: 8]; for a 6-bit idx that top bit
            // is {~idx, 3'b111}.
            blk_q[{~idx, 3'b111} -: 8] <= byte_i;
            idx    <= idx + 6'd1;
            bitlen <= bitlen_inc;
            if (idx == 6'd63) begin
              state        <= SEND;
              byte_ready_o <= 1'b0;
              blk_valid_o  <= 1'b1;
              blk_first_o  <= first_flag;
              blk_final_o  <= 1'b0;
              pend_pad0    <= byte_last_i;
              busy_o       <= 1'b1;
            end else if (byte_last_i) begin
              state        <= PAD;
              byte_ready_o <= 1'b0;
              busy_o       <= 1'b1;
            end else begin
              busy_o <= (bitlen_inc != '0);
            end
          end
        end

        PAD: begin
          for (int unsigned k = 0; k < 64; k++) begin
            if (k == 32'(idx)) begin
              blk_q[511 - 8*k -: 8] <= 8'h80;
            end else if (k > 32'(idx)) begin
              blk_q[511 - 8*k -: 8] <= 8'h00;
            end
          end
          // Length fits behind the 0x80 marker only if idx <= 55; the later
          // assignment to [63:0] overrides the zero fill above.
          if (idx <= 6'd55) begin
            blk_q[63:0] <= len64;
            blk_final_o <= 1'b1;
          end else begin
            blk_final_o <= 1'b0;
            pend_len    <= 1'b1;
          end
          blk_first_o <= first_flag;
          blk_valid_o <= 1'b1;
          state       <= SEND;
        end

        SEND: begin
          if (core_ready_i) begin
            first_flag  <= 1'b0;
            blk_valid_o <= 1'b0;
            if (blk_final_o) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else if (pend_pad0) begin
              pend_pad0 <= 1'b0;
              idx       <= '0;
              state     <= PAD;
            end else if (pend_len) begin
              pend_len <= 1'b0;
              state    <= LENBLK;
            end else begin
              idx          <= '0;
              byte_ready_o <= 1'b1;
              state        <= COLLECT;
            end
          end
        end

        LENBLK: begin
          blk_q       <= {448'h0, len64};
          blk_first_o <= first_flag;
          blk_final_o <= 1'b1;
          blk_valid_o <= 1'b1;
          state       <= SEND;
        end

        DONE: begin
          bitlen       <= '0;
          idx          <= '0;
          pend_pad0    <= 1'b0;
          pend_len     <= 1'b0;
          first_flag   <= 1'b1;
          blk_first_o  <= 1'b0;
          blk_final_o  <= 1'b0;
          byte_ready_o <= 1'b1;
          busy_o       <= 1'b0;
          state        <= COLLECT;
        end

        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_pad_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for sha256_pad_ctrl: a message-level padding model
// produces the expected block sequence, checked on every cycle.
module tb_sha256_pad_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         byte_valid_i;
  logic [7:0]   byte_i;
  logic         byte_last_i;
  logic         byte_ready_o;
  logic [511:0] blk_o;
  logic         blk_valid_o;
  logic         blk_first_o;
  logic         blk_final_o;
  logic         core_ready_i;
  logic         done_o;
  logic         busy_o;

  sha256_pad_ctrl #(.LEN_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_last_i  (byte_last_i),
    .byte_ready_o (byte_ready_o),
    .blk_o        (blk_o),
    .blk_valid_o  (blk_valid_o),
    .blk_first_o  (blk_first_o),
    .blk_final_o  (blk_final_o),
    .core_ready_i (core_ready_i),
    .done_o       (done_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         fin;
  } eblk_t;

  eblk_t exp_q[$];
  eblk_t mq[$];
  int    errors = 0;
  int    checks = 0;
  int    msg_started = 0;
  int    msg_done = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Standard SHA-256 padding of a whole message, split into 64-byte blocks.
  function automatic void build_model(input bq_t msg);
    bq_t          p;
    logic [63:0]  bl;
    logic [511:0] b;
    eblk_t        e;
    int           nblk;
    p  = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    mq.delete();
    nblk = p.size() / 64;
    for (int n = 0; n < nblk; n++) begin
      b = '0;
      for (int j = 0; j < 64; j++) b = {b[503:0], p[n*64 + j]};
      e.blk   = b;
      e.first = (n == 0);
      e.fin   = (n == nblk - 1);
      mq.push_back(e);
    end
  endfunction

  function automatic bq_t mk(input int n, input logic [7:0] base, input bit inc);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(inc ? base + 8'(i) : base);
    return q;
  endfunction

  task automatic push_exp();
    foreach (mq[i]) exp_q.push_back(mq[i]);
  endtask

  task automatic send_msg(input bq_t msg, input bit with_last);
    bit r;
    bit acc;
    for (int i = 0; i < msg.size(); i++) begin
      byte_valid_i = 1'b1;
      byte_i       = msg[i];
      byte_last_i  = with_last && (i == msg.size() - 1);
      acc = 1'b0;
      for (int t = 0; t < 300 && !acc; t++) begin
        @(negedge clk);
        r = byte_ready_o;
        @(posedge clk);
        #1;
        acc = r;
      end
      if (!acc) begin
        check("byte accept timeout", acc, 1);
        break;
      end
      if (i == 0) msg_started++;
    end
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    int t;
    start = msg_done;
    t = 0;
    while (msg_done == start && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("done within budget", msg_done != start, 1);
    check("all blocks delivered", exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!blk_valid_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, blk_valid_o, 1);
  endtask

  // Per-cycle compare of all DUT outputs against the block model.
  initial begin
    bit hs_fin;
    hs_fin = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs_fin = 1'b0;
      end else begin
        check("done_o", done_o, hs_fin);
        check("busy_o", busy_o, msg_started != msg_done);
        if (hs_fin) msg_done++;
        hs_fin = 1'b0;
        if (blk_valid_o) begin
          check("byte_ready_o while block pending", byte_ready_o, 0);
          if (exp_q.size() == 0) begin
            check("blk_valid_o with no block expected", blk_valid_o, 0);
          end else begin
            check("blk_o", blk_o, exp_q[0].blk);
            check("blk_first_o", blk_first_o, exp_q[0].first);
            check("blk_final_o", blk_final_o, exp_q[0].fin);
            if (core_ready_i) begin
              hs_fin = exp_q[0].fin;
              void'(exp_q.pop_front());
            end
          end
        end else if (done_o) begin
          check("byte_ready_o during done", byte_ready_o, 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] held;
    logic [7:0]   bsel;

    rst          = 1'b1;
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
    byte_last_i  = 1'b0;
    core_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset byte_ready_o", byte_ready_o, 1);
    check("reset blk_valid_o", blk_valid_o, 0);
    check("reset blk_o", blk_o, 0);
    check("reset first/final", {blk_first_o, blk_final_o}, 0);
    check("reset done/busy", {done_o, busy_o}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // "abc": single block, partial-block latency through PAD
    build_model('{8'h61, 8'h62, 8'h63});
    check("abc model nblk", mq.size(), 1);
    check("abc model block", mq[0].blk, {32'h61626380, 416'h0, 64'h18});
    push_exp();
    send_msg('{8'h61, 8'h62, 8'h63}, 1'b1);
    @(negedge clk);
    check("abc valid low in pad cycle", blk_valid_o, 0);
    @(negedge clk);
    check("abc valid two cycles after last byte", blk_valid_o, 1);
    wait_done();

    // 55 bytes: length still fits in the single block
    build_model(mk(55, 8'h41, 1'b0));
    check("55 model nblk", mq.size(), 1);
    bsel = mq[0].blk[71:64];
    check("55 model byte55", bsel, 8'h80);
    check("55 model length", mq[0].blk[63:0], 64'h1B8);
    push_exp();
    send_msg(mk(55, 8'h41, 1'b0), 1'b1);
    wait_done();

    // 56 bytes: marker fits, length moves to an extra block
    build_model(mk(56, 8'h41, 1'b0));
    check("56 model nblk", mq.size(), 2);
    check("56 model blk1 tail", mq[0].blk[63:0], 64'h8000000000000000);
    check("56 model blk2", mq[1].blk, 512'h1C0);
    push_exp();
    send_msg(mk(56, 8'h41, 1'b0), 1'b1);
    wait_done();

    // 64 bytes: full data block, then padding-only block
    build_model(mk(64, 8'h00, 1'b1));
    check("64 model nblk", mq.size(), 2);
    check("64 model blk2", mq[1].blk, {8'h80, 440'h0, 64'h200});
    push_exp();
    send_msg(mk(64, 8'h00, 1'b1), 1'b1);
    @(negedge clk);
    check("64 valid cycle after 64th byte", blk_valid_o, 1);
    wait_done();

    // Backpressure: core stalls 5 cycles during SEND
    core_ready_i = 1'b0;
    build_model(mk(10, 8'h30, 1'b1));
    push_exp();
    send_msg(mk(10, 8'h30, 1'b1), 1'b1);
    wait_valid("backpressure block appears");
    held = blk_o;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("stall blk_valid_o", blk_valid_o, 1);
      check("stall byte_ready_o", byte_ready_o, 0);
      check("stall blk_o stable", blk_o, held);
    end
    @(posedge clk);
    #1;
    core_ready_i = 1'b1;
    wait_done();

    // Reset in the middle of SEND of a 100-byte message, then "abc"
    core_ready_i = 1'b0;
    build_model(mk(100, 8'h10, 1'b1));
    push_exp();
    send_msg(mk(64, 8'h10, 1'b1), 1'b0);
    wait_valid("100-byte first block appears");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async reset drops blk_valid_o", blk_valid_o, 0);
    check("async reset byte_ready_o", byte_ready_o, 1);
    check("async reset busy_o", busy_o, 0);
    exp_q.delete();
    msg_started = msg_done;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    core_ready_i = 1'b1;
    build_model('{8'h61, 8'h62, 8'h63});
    check("abc after reset model first", mq[0].first, 1);
    push_exp();
    send_msg('{8'h61, 8'h62, 8'h63}, 1'b1);
    wait_done();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
